guitar_effect_sequencer: RTL and testbench
==========================================

Name: guitar_effect_sequencer

Overview:
Avalon-MM master that sequences the guitar_effect register slave once per audio sample.
- Optionally applies a pending gain/boost configuration.
- Writes the ADC sample to ADD_INPUT, waits for the effect to process it, then reads ADD_OUTPUT and presents the result to the DAC path.
- Sits between the codec sample-rate front end and guitar_effect's avl_* port, and counts dropped samples (overruns).

Parameters:
- PROC_CYCLES, 4, cycles waited between the ADD_INPUT write and the ADD_OUTPUT read (1..255).
- READ_LATENCY, 1, cycles from avm_read assertion to valid avm_readdata (1..7).
- OVR_W, 16, width of the overrun counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-low.
- sample_tick  in  1  one-cycle strobe marking a new sample; adc_data is valid in that cycle.
- adc_data  in  32  input sample.
- cfg_req  in  1  level request to apply cfg_gain/cfg_boost; held until cfg_ack.
- cfg_gain  in  32  distortion gain value; stable while cfg_req is high.
- cfg_boost  in  32  distortion boost value; stable while cfg_req is high.
- cfg_ack  out  1  one-cycle pulse when the configuration has been written.
- dac_data  out  32  last processed sample.
- dac_valid  out  1  one-cycle pulse when dac_data is updated.
- busy  out  1  high in every state except IDLE.
- overrun_cnt  out  OVR_W  saturating count of dropped ticks.
- avm_address  out  5  slave register address.
- avm_writedata  out  32  write data.
- avm_write  out  1  write strobe (one cycle per access).
- avm_read  out  1  read strobe (one cycle per access).
- avm_readdata  in  32  read data.

Behaviour:
- Reset (reset=0 at a clk edge):
  - State goes to IDLE; all outputs go to 0, including the avm_* outputs, dac_data and overrun_cnt.
  - The latched sample is cleared, and any in-flight access is abandoned without completion.
- Accesses:
  - Every avm access lasts exactly one cycle. Address and data are registered, and read and write are never high together.
  - Outside access cycles avm_address and avm_writedata hold their last value, and the strobes are 0.
- States: IDLE, CFG_GAIN, CFG_BOOST, WR_IN, WAIT, RD, RD_WAIT.
- IDLE:
  - sample_tick=1: latch adc_data. If cfg_req=1, go to CFG_GAIN; otherwise go to WR_IN.
  - sample_tick=0 and cfg_req=1: go to CFG_GAIN as a configuration-only pass.
  - Otherwise stay in IDLE.
- CFG_GAIN: avm_write=1, address 5'b00001, data cfg_gain. Next state is CFG_BOOST.
- CFG_BOOST:
  - avm_write=1, address 5'b00010, data cfg_boost, and cfg_ack=1 in this cycle.
  - Next state is WR_IN if a sample is latched, otherwise IDLE.
- cfg_req sampled again in the cycle after cfg_ack is treated as a new request. The requester must drop cfg_req on cfg_ack.
- WR_IN: avm_write=1, address 5'b00110, data = latched sample. Next state is WAIT, with the wait counter loaded to PROC_CYCLES.
- WAIT: stay for exactly PROC_CYCLES cycles, then go to RD.
- RD: avm_read=1, address 5'b00101. Next state is RD_WAIT.
- RD_WAIT:
  - Stay for READ_LATENCY cycles. On the last cycle, capture avm_readdata into dac_data.
  - Go to IDLE with dac_valid=1 in the first IDLE cycle.
- Latency, tick cycle to dac_valid cycle: 3+PROC_CYCLES+READ_LATENCY cycles, plus 2 if a configuration is applied. With the defaults this is 8 cycles (10 with configuration).
- Overrun:
  - A sample_tick in any non-IDLE state is dropped and overrun_cnt increments.
  - overrun_cnt saturates at 2^OVR_W-1.
  - A tick in the IDLE cycle that carries dac_valid is accepted.
- Simultaneous cfg_req and sample_tick: configuration is applied first, inside the same sample slot.
- cfg_req arriving mid-sample: stays pending and is serviced at the next IDLE.

Decomposition:
- Shared package guitar_effect_pkg holds:
  - Register address constants: ADD_DISTORTION_GAIN=1, ADD_DISTORTION_BOOST=2, ADD_STATUS=3, ADD_OUTPUT=5, ADD_INPUT=6.
  - Address width 5 and data width 32.
  - The sequencer state encoding.
- No sub-module: the wait/latency down-counter and the saturating overrun counter stay inline.

Test Plan:
- Reset at cycle 0 with sample_tick=1 -> all outputs 0, no avm strobe, overrun_cnt 0.
- Tick with adc_data=32'd10, no cfg, readdata model returns 32'd20 -> exactly these accesses:
  - write addr 6 data 10 at tick+1;
  - read addr 5 at tick+6;
  - dac_data=20 with dac_valid pulse at tick+8;
  - busy high from tick+1 to tick+7.
- cfg_req with gain=1, boost=2 and a tick in the same cycle -> writes addr 1 data 1 at +1, addr 2 data 2 at +2 with cfg_ack, addr 6 at +3, dac_valid at +10.
- Tick then a second tick at tick+4 -> second dropped, overrun_cnt=1, one dac_valid only. Repeat 2^OVR_W+2 times with OVR_W=2 -> saturates at 3.
- Back-to-back ticks every 8 cycles (tick coinciding with dac_valid) -> every sample accepted, overrun_cnt stays 0.
- reset=0 asserted during WAIT -> next cycle IDLE with all outputs 0. A tick after release runs a full clean sequence.

Source files
------------

// File: rtl/guitar_effect_pkg.sv
// Shared definitions for the guitar_effect register slave and its sequencer:
// register map, bus widths and the sequencer state encoding.
package guitar_effect_pkg;

  localparam int AW = 5;
  localparam int DW = 32;

  localparam logic [AW-1:0] ADD_DISTORTION_GAIN  = 5'd1;
  localparam logic [AW-1:0] ADD_DISTORTION_BOOST = 5'd2;
  localparam logic [AW-1:0] ADD_STATUS           = 5'd3;
  localparam logic [AW-1:0] ADD_OUTPUT           = 5'd5;
  localparam logic [AW-1:0] ADD_INPUT            = 5'd6;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CFG_GAIN  = 3'd1,
    ST_CFG_BOOST = 3'd2,
    ST_WR_IN     = 3'd3,
    ST_WAIT      = 3'd4,
    ST_RD        = 3'd5,
    ST_RD_WAIT   = 3'd6
  } seq_state_t;

endpackage

// File: rtl/guitar_effect_sequencer.sv
// Avalon-MM master that runs one guitar_effect pass per audio sample:
// optional gain/boost update, input write, processing wait, output read.
//
// state        | meaning
// IDLE         | waiting for sample_tick or cfg_req
// CFG_GAIN     | writing distortion gain
// CFG_BOOST    | writing distortion boost, cfg_ack pulses
// WR_IN        | writing latched sample to ADD_INPUT
// WAIT         | effect processing, PROC_CYCLES cycles
// RD           | read strobe on ADD_OUTPUT
// RD_WAIT      | READ_LATENCY cycles, capture readdata on the last one
module guitar_effect_sequencer
  import guitar_effect_pkg::*;
#(
  parameter int PROC_CYCLES  = 4,
  parameter int READ_LATENCY = 1,
  parameter int OVR_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_tick,
  input  logic [DW-1:0]    adc_data,
  input  logic             cfg_req,
  input  logic [DW-1:0]    cfg_gain,
  input  logic [DW-1:0]    cfg_boost,
  output logic             cfg_ack,
  output logic [DW-1:0]    dac_data,
  output logic             dac_valid,
  output logic             busy,
  output logic [OVR_W-1:0] overrun_cnt,
  output logic [AW-1:0]    avm_address,
  output logic [DW-1:0]    avm_writedata,
  output logic             avm_write,
  output logic             avm_read,
  input  logic [DW-1:0]    avm_readdata
);

  localparam logic [7:0]       PROC_LOAD  = 8'(PROC_CYCLES);
  localparam logic [7:0]       RDLAT_LOAD = 8'(READ_LATENCY);
  localparam logic [OVR_W-1:0] OVR_MAX    = '1;

  seq_state_t       state, state_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [DW-1:0]    sample, sample_nxt;
  logic             sample_vld, sample_vld_nxt;
  logic [OVR_W-1:0] ovr_nxt;
  logic [AW-1:0]    addr_nxt;
  logic [DW-1:0]    wdata_nxt;
  logic             write_nxt, read_nxt, ack_nxt, dvalid_nxt;
  logic [DW-1:0]    dac_nxt;

  assign busy = (state != ST_IDLE);

  // Bus outputs are computed one cycle ahead so they appear registered
  // in the same cycle the FSM sits in the corresponding access state.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    sample_nxt     = sample;
    sample_vld_nxt = sample_vld;
    addr_nxt       = avm_address;
    wdata_nxt      = avm_writedata;
    write_nxt      = 1'b0;
    read_nxt       = 1'b0;
    ack_nxt        = 1'b0;
    dvalid_nxt     = 1'b0;
    dac_nxt        = dac_data;
    ovr_nxt        = overrun_cnt;

    if (sample_tick && (state != ST_IDLE) && (overrun_cnt != OVR_MAX))
      ovr_nxt = overrun_cnt + 1'b1;

    case (state)
      ST_IDLE: begin
        if (sample_tick) begin
          sample_nxt     = adc_data;
          sample_vld_nxt = 1'b1;
        end
        if (cfg_req) begin
          state_nxt = ST_CFG_GAIN;
          write_nxt = 1'b1;
          addr_nxt  = ADD_DISTORTION_GAIN;
          wdata_nxt = cfg_gain;
        end else if (sample_tick) begin
          state_nxt = ST_WR_IN;
          write_nxt = 1'b1;
          addr_nxt  = ADD_INPUT;
          wdata_nxt = adc_data;
        end
      end
      ST_CFG_GAIN: begin
        state_nxt = ST_CFG_BOOST;
        write_nxt = 1'b1;
        addr_nxt  = ADD_DISTORTION_BOOST;
        wdata_nxt = cfg_boost;
        ack_nxt   = 1'b1;
      end
      ST_CFG_BOOST: begin
        if (sample_vld) begin
          state_nxt = ST_WR_IN;
          write_nxt = 1'b1;
          addr_nxt  = ADD_INPUT;
          wdata_nxt = sample;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WR_IN: begin
        state_nxt      = ST_WAIT;
        cnt_nxt        = PROC_LOAD;
        sample_vld_nxt = 1'b0;
      end
      ST_WAIT: begin
        if (cnt == 8'd1) begin
          state_nxt = ST_RD;
          read_nxt  = 1'b1;
          addr_nxt  = ADD_OUTPUT;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      ST_RD: begin
        state_nxt = ST_RD_WAIT;
        cnt_nxt   = RDLAT_LOAD;
      end
      ST_RD_WAIT: begin
        if (cnt == 8'd1) begin
          state_nxt  = ST_IDLE;
          dac_nxt    = avm_readdata;
          dvalid_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      sample        <= '0;
      sample_vld    <= 1'b0;
      overrun_cnt   <= '0;
      avm_address   <= '0;
      avm_writedata <= '0;
      avm_write     <= 1'b0;
      avm_read      <= 1'b0;
      cfg_ack       <= 1'b0;
      dac_valid     <= 1'b0;
      dac_data      <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      sample        <= sample_nxt;
      sample_vld    <= sample_vld_nxt;
      overrun_cnt   <= ovr_nxt;
      avm_address   <= addr_nxt;
      avm_writedata <= wdata_nxt;
      avm_write     <= write_nxt;
      avm_read      <= read_nxt;
      cfg_ack       <= ack_nxt;
      dac_valid     <= dvalid_nxt;
      dac_data      <= dac_nxt;
    end
  end

endmodule

// File: tb/tb_guitar_effect_sequencer.sv
// Randomized bench: a transaction-level model predicts every bus access and
// DAC update; a negedge monitor pops the expectations and compares.
module tb_guitar_effect_sequencer;

  localparam int P  = 4;
  localparam int L  = 1;
  localparam int OW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_tick;
  logic [31:0]   adc_data;
  logic          cfg_req;
  logic [31:0]   cfg_gain;
  logic [31:0]   cfg_boost;
  logic          cfg_ack;
  logic [31:0]   dac_data;
  logic          dac_valid;
  logic          busy;
  logic [OW-1:0] overrun_cnt;
  logic [4:0]    avm_address;
  logic [31:0]   avm_writedata;
  logic          avm_write;
  logic          avm_read;
  logic [31:0]   avm_readdata;

  always #5 clk = ~clk;

  guitar_effect_sequencer #(
    .PROC_CYCLES (P),
    .READ_LATENCY(L),
    .OVR_W       (OW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .adc_data     (adc_data),
    .cfg_req      (cfg_req),
    .cfg_gain     (cfg_gain),
    .cfg_boost    (cfg_boost),
    .cfg_ack      (cfg_ack),
    .dac_data     (dac_data),
    .dac_valid    (dac_valid),
    .busy         (busy),
    .overrun_cnt  (overrun_cnt),
    .avm_address  (avm_address),
    .avm_writedata(avm_writedata),
    .avm_write    (avm_write),
    .avm_read     (avm_read),
    .avm_readdata (avm_readdata)
  );

  // kind: 0 = write, 1 = read, 2 = dac update
  typedef struct {
    int          cyc;
    int          kind;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        ack;
  } ev_t;

  ev_t  exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cur         = 0;
  int   free_at     = 0;
  int   ovr_m       = 0;
  bit   rst_prev    = 1'b1;
  bit   busy_vis    = 1'b0;
  bit   zero_vis    = 1'b0;
  int   ovr_vis     = 0;
  bit   cfg_active  = 1'b0;
  int   ack_cyc     = -1;
  logic [31:0] last_in = '0;
  int   rd_due[$];

  function automatic void push_ev(input int c, input int k, input logic [4:0] a,
                                  input logic [31:0] d, input logic ack);
    ev_t e;
    e.cyc = c; e.kind = k; e.addr = a; e.data = d; e.ack = ack;
    exp_q.push_back(e);
  endfunction

  // One clock interval: slave response, input drive, then model update.
  task automatic step(input bit t, input logic [31:0] d, input bit rst_n,
                      input bit want_cfg, input logic [31:0] g, input logic [31:0] b);
    int   off;
    ev_t  keep[$];
    @(posedge clk);
    #1;
    cur++;

    avm_readdata = $urandom;
    if (rd_due.size() > 0 && rd_due[0] == cur) begin
      avm_readdata = last_in << 1;
      void'(rd_due.pop_front());
    end
    if (avm_write && avm_address == 5'd6) last_in = avm_writedata;
    if (avm_read) rd_due.push_back(cur + L);

    busy_vis = (cur < free_at);
    ovr_vis  = ovr_m;
    zero_vis = rst_prev;

    reset       = rst_n;
    sample_tick = t;
    adc_data    = d;
    if (cfg_active && ack_cyc >= 0 && cur > ack_cyc) begin
      cfg_req    = 1'b0;
      cfg_active = 1'b0;
      ack_cyc    = -1;
    end else if (!cfg_active && want_cfg) begin
      cfg_req    = 1'b1;
      cfg_gain   = g;
      cfg_boost  = b;
      cfg_active = 1'b1;
      ack_cyc    = -1;
    end

    if (!rst_n) begin
      foreach (exp_q[k]) if (exp_q[k].cyc <= cur) keep.push_back(exp_q[k]);
      exp_q    = keep;
      free_at  = cur + 1;
      ovr_m    = 0;
      rst_prev = 1'b1;
      rd_due.delete();
      if (ack_cyc > cur) ack_cyc = -1;
    end else begin
      rst_prev = 1'b0;
      if (cur >= free_at) begin
        off = cfg_req ? 2 : 0;
        if (cfg_req) begin
          push_ev(cur + 1, 0, 5'd1, cfg_gain, 1'b0);
          push_ev(cur + 2, 0, 5'd2, cfg_boost, 1'b1);
          ack_cyc = cur + 2;
        end
        if (t) begin
          push_ev(cur + 1 + off, 0, 5'd6, d, 1'b0);
          push_ev(cur + off + 2 + P, 1, 5'd5, 32'd0, 1'b0);
          push_ev(cur + off + 3 + P + L, 2, 5'd0, d << 1, 1'b0);
          free_at = cur + off + 3 + P + L;
        end else if (cfg_req) begin
          free_at = cur + 3;
        end
      end else if (t && ovr_m < (1 << OW) - 1) begin
        ovr_m++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
  endtask

  ev_t mon_e;
  bit  mon_ok;

  always @(negedge clk) begin
    if (cur >= 1) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cur) begin
        vectors++;
        miscompares++;
        $display("FAIL missing_event cyc=%0d kind=%0d addr=%0d: DUT showed no access, required one",
                 exp_q[0].cyc, exp_q[0].kind, exp_q[0].addr);
        void'(exp_q.pop_front());
      end
      if (avm_write || avm_read || dac_valid || cfg_ack) begin
        vectors++;
        if (exp_q.size() > 0 && exp_q[0].cyc == cur) begin
          mon_e = exp_q.pop_front();
          case (mon_e.kind)
            0: mon_ok = avm_write && !avm_read && !dac_valid && avm_address == mon_e.addr &&
                        avm_writedata == mon_e.data && cfg_ack == mon_e.ack;
            1: mon_ok = avm_read && !avm_write && !dac_valid && !cfg_ack &&
                        avm_address == mon_e.addr;
            default: mon_ok = dac_valid && !avm_write && !avm_read && !cfg_ack &&
                              dac_data == mon_e.data;
          endcase
          if (!mon_ok) begin
            miscompares++;
            $display("FAIL event cyc=%0d kind=%0d: got wr=%0b rd=%0b ack=%0b dv=%0b addr=%0d wd=%h dac=%h, required addr=%0d data=%h ack=%0b",
                     cur, mon_e.kind, avm_write, avm_read, cfg_ack, dac_valid, avm_address,
                     avm_writedata, dac_data, mon_e.addr, mon_e.data, mon_e.ack);
          end
        end else begin
          miscompares++;
          $display("FAIL unexpected_output cyc=%0d: got wr=%0b rd=%0b ack=%0b dv=%0b addr=%0d, required none",
                   cur, avm_write, avm_read, cfg_ack, dac_valid, avm_address);
        end
      end
      vectors++;
      if (busy !== busy_vis) begin
        miscompares++;
        $display("FAIL busy cyc=%0d: got %b, required %b", cur, busy, busy_vis);
      end
      vectors++;
      if (overrun_cnt !== OW'(ovr_vis)) begin
        miscompares++;
        $display("FAIL overrun_cnt cyc=%0d: got %0d, required %0d", cur, overrun_cnt, ovr_vis);
      end
      if (zero_vis) begin
        vectors++;
        if (cfg_ack !== 1'b0 || dac_data !== 32'd0 || dac_valid !== 1'b0 || busy !== 1'b0 ||
            overrun_cnt !== '0 || avm_address !== 5'd0 || avm_writedata !== 32'd0 ||
            avm_write !== 1'b0 || avm_read !== 1'b0) begin
          miscompares++;
          $display("FAIL reset_state cyc=%0d: got addr=%0d wd=%h wr=%b rd=%b dac=%h dv=%b ack=%b ovr=%0d busy=%b, required all 0",
                   cur, avm_address, avm_writedata, avm_write, avm_read, dac_data, dac_valid,
                   cfg_ack, overrun_cnt, busy);
        end
      end
    end
  end

  initial begin
    reset        = 1'b0;
    sample_tick  = 1'b1;
    adc_data     = 32'd0;
    cfg_req      = 1'b0;
    cfg_gain     = 32'd0;
    cfg_boost    = 32'd0;
    avm_readdata = 32'd0;

    repeat (2) step(1'b1, 32'd123, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(3);

    step(1'b1, 32'd10, 1'b1, 1'b0, 32'd0, 32'd0);
    idle(12);

    step(1'b1, 32'd77, 1'b1, 1'b1, 32'd1, 32'd2);
    idle(14);

    for (int k = 0; k < 10; k++) begin
      step(1'b1, $urandom, 1'b1, 1'b0, 32'd0, 32'd0);
      idle(7);
    end
    idle(10);

    for (int k = 0; k < 6; k++) begin
      step(1'b1, $urandom, 1'b1, 1'b0, 32'd0, 32'd0);
      idle(3);
      step(1'b1, $urandom, 1'b1, 1'b0, 32'd0, 32'd0);
      idle(10);
    end

    step(1'b1, $urandom, 1'b1, 1'b0, 32'd0, 32'd0);
    idle(2);
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(3);
    step(1'b1, 32'd55, 1'b1, 1'b0, 32'd0, 32'd0);
    idle(12);

    for (int k = 0; k < 1500; k++) begin
      step($urandom_range(5) == 0, $urandom, $urandom_range(399) != 0,
           $urandom_range(19) == 0, $urandom, $urandom);
    end
    idle(25);

    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_events: got %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
